// File: rtl/exmem_pipe_stage.sv
// rtl/exmem_pipe_stage.sv - EX/MEM pipeline stage with valid/ready handshake and 2-entry skid buffer
// Optional EXMEM_PERF_CNT_EN adds saturating stall/bubble counters.
module exmem_pipe_stage #(
  parameter int DATA_W    = 16,
  parameter int NUM_DATA  = 3,
  parameter int REGADDR_W = 4,
  parameter int CTRL_W    = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          ctrl_in,
  input  logic [NUM_DATA*DATA_W-1:0] data_in,
  input  logic [REGADDR_W-1:0]       regdes_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          ctrl_out,
  output logic [NUM_DATA*DATA_W-1:0] data_out,
  output logic [REGADDR_W-1:0]       regdes_out,
  output logic                       fwd_valid,
`ifdef EXMEM_PERF_CNT_EN
  output logic [15:0]                stall_cnt,
  output logic [15:0]                bubble_cnt,
`endif
  output logic [DATA_W-1:0]          fwd_data
);

  localparam int DW = NUM_DATA * DATA_W;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_next;

  logic [CTRL_W-1:0]    h_ctrl, s_ctrl;
  logic [DW-1:0]        h_data, s_data;
  logic [REGADDR_W-1:0] h_reg, s_reg;

  logic accept, pop;
  logic load_h_in, load_h_s, load_s_in, drain_h;

  // Occupancy state is itself a register, so handshake outputs carry no
  // combinational path from out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_h_in  = 1'b0;
    load_h_s   = 1'b0;
    load_s_in  = 1'b0;
    drain_h    = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            load_h_in  = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_h_in = 1'b1;
          end else if (accept) begin
            state_next = FULL;
            load_s_in  = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
            drain_h    = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            state_next = ONE;
            load_h_s   = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Head control is zeroed whenever the head empties, so a bubble never
  // carries write enables while data/regdes simply hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_ctrl <= '0;
      h_data <= '0;
      h_reg  <= '0;
    end else if (flush || drain_h) begin
      h_ctrl <= '0;
    end else if (load_h_in) begin
      h_ctrl <= ctrl_in;
      h_data <= data_in;
      h_reg  <= regdes_in;
    end else if (load_h_s) begin
      h_ctrl <= s_ctrl;
      h_data <= s_data;
      h_reg  <= s_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ctrl <= '0;
      s_data <= '0;
      s_reg  <= '0;
    end else if (load_s_in) begin
      s_ctrl <= ctrl_in;
      s_data <= data_in;
      s_reg  <= regdes_in;
    end
  end

  assign ctrl_out   = h_ctrl;
  assign data_out   = h_data;
  assign regdes_out = h_reg;
  assign fwd_valid  = out_valid & h_ctrl[0];
  assign fwd_data   = h_data[DATA_W-1:0];

`ifdef EXMEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (!out_valid && !flush && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule
